layer_pool_stream: RTL and testbench
====================================

LAYER_POOL_STREAM -- requirements
Module: layer_pool_stream

Interface
REQ-001 SHALL have parameter BITS, default 16, signed two's-complement width of one channel sample.
REQ-002 SHALL have parameter CH, default 16, channels packed per pixel; channel k occupies bits [k*BITS +: BITS].
REQ-003 SHALL have parameters IMG_W, default 24, and IMG_H, default 24: input frame size in pixels; both even and >= 2.
REQ-004 SHALL have port clk_in, input, 1 bit: the single clock; all state on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1 bit: single-cycle pulse that begins a frame and samples mode.
REQ-007 SHALL have port mode, input, 1 bit: 0 = 2x2 max pooling, 1 = 2x2 average pooling.
REQ-008 SHALL have port in_valid, input, 1 bit: in_data carries one pixel this cycle.
REQ-009 SHALL have port in_data, input, CH*BITS bits: one input pixel, raster order, row-major.
REQ-010 SHALL have port out_valid, output, 1 bit: out_data holds one pooled pixel this cycle.
REQ-011 SHALL have port out_data, output, CH*BITS bits: pooled pixel, same channel packing.
REQ-012 SHALL have port busy, output, 1 bit: high from start until the last pooled pixel of the frame is emitted.
REQ-013 SHALL have port frame_done, output, 1 bit: one-cycle pulse coincident with the last out_valid of the frame.

Function
REQ-014 SHALL implement FSM IDLE -> RUN on start; RUN -> IDLE in the cycle the final pooled pixel (row IMG_H-1, col IMG_W-1) is registered.
REQ-015 SHALL ignore in_valid in IDLE; gaps (in_valid low) in RUN SHALL stall counters without altering state.
REQ-016 SHALL track col (0..IMG_W-1) and row (0..IMG_H-1) counters, advancing col on each accepted beat and wrapping col to 0 with row+1.
REQ-017 SHALL latch mode on start; mode changes during RUN SHALL have no effect until the next start.
REQ-018 SHALL, per channel, combine horizontal pairs: even col stores sample; odd col forms pair result (max, or sign-extended sum in BITS+1 bits).
REQ-019 SHALL hold pair results of even rows in a line buffer of IMG_W/2 entries per channel, indexed col>>1.
REQ-020 SHALL, on odd row and odd col, combine buffered and current pair results: max of both, or BITS+2-bit signed sum arithmetically shifted right 2 (floor).
REQ-021 SHALL register the result: out_valid high exactly one cycle after the accepted beat at odd row, odd col; otherwise low.
REQ-022 SHALL emit exactly (IMG_W/2)*(IMG_H/2) out_valid pulses per frame, in pooled raster order.
REQ-023 SHALL use signed comparison for max; equal operands yield that value.
REQ-024 SHALL, when start arrives during RUN, discard the partial frame, zero counters, relatch mode and restart in RUN; the same-cycle in_valid beat SHALL be ignored.
REQ-025 SHALL hold out_data at its last value when out_valid is low.
REQ-026 SHALL assert busy in the cycle after start and deassert it in the cycle after frame_done.

Reset
REQ-027 SHALL on rst_n low asynchronously force FSM to IDLE, counters, latched mode, out_valid, out_data, busy and frame_done to 0.
REQ-028 SHALL NOT require line buffer contents to be reset; they are always written before read.
REQ-029 SHALL, on reset mid-frame, abandon the frame; no output until the next start.

Structure
REQ-030 SHALL place mode encodings (POOL_MAX=0, POOL_AVG=1) and FSM state encodings in shared package pool_pkg.
REQ-031 SHALL instantiate one sub-module pool_ch_unit per channel (pair combine, line buffer, final combine), CH instances via generate; counters and FSM SHALL be shared in the top.

Verification (BITS=16, CH=2, IMG_W=4, IMG_H=4)
REQ-032 SHALL verify max mode: ch0 pixels 0..15 in raster, ch1 = -(ch0) -> four outputs ch0 {5,7,13,15}, ch1 {0,-2,-8,-10}, frame_done with 4th.
REQ-033 SHALL verify avg mode: same stimulus -> ch0 {2,4,10,12} (floor of 2.5,4.5,10.5,12.5), ch1 {-3,-5,-11,-13}.
REQ-034 SHALL verify saturating extremes: all ch0 = 32767, ch1 = -32768, avg mode -> outputs 32767 and -32768, no overflow.
REQ-035 SHALL verify stalls: random in_valid gaps of 0-3 cycles -> identical output sequence to REQ-032, each out_valid one cycle after triggering beat.
REQ-036 SHALL verify restart/reset: start after 6 beats then full frame -> exactly 4 outputs from new frame; rst_n low mid-frame -> out_valid, busy 0 immediately, no outputs until start.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared encodings for the 2x2 pooling stream: pooling mode, control FSM states,
// and a counter-width helper.
package pool_pkg;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } pool_state_e;

  // At least 2 bits so that col>>1 always has a non-empty index slice.
  function automatic int ctr_width(input int n);
    return (n > 2) ? $clog2(n) : 2;
  endfunction

endpackage

// File: rtl/pool_ch_unit.sv
// One channel of 2x2 pooling: horizontal pair combine, line buffer of even-row
// pair results, and the final vertical combine (max or floor average).
module pool_ch_unit
  import pool_pkg::*;
#(
  parameter int BITS  = 16,
  parameter int IMG_W = 24,
  parameter int IDX_W = 4
) (
  input  logic                   clk_in,
  input  logic                   accept,
  input  logic                   col_odd,
  input  logic                   row_odd,
  input  logic [IDX_W-1:0]       idx,
  input  pool_mode_e             mode,
  input  logic signed [BITS-1:0] sample,
  output logic [BITS-1:0]        result
);

  logic signed [BITS-1:0] held_q;
  logic signed [BITS:0]   pair;
  logic signed [BITS:0]   buf_rd;
  logic signed [BITS:0]   line_buf [IMG_W/2];
  logic signed [BITS+1:0] quad_sum;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    pair = {held_q[BITS-1], held_q} + {sample[BITS-1], sample};
    if (mode == POOL_MAX) begin
      pair = (held_q >= sample) ? {held_q[BITS-1], held_q} : {sample[BITS-1], sample};
    end
  end

  assign buf_rd   = line_buf[idx];
  assign quad_sum = {buf_rd[BITS], buf_rd} + {pair[BITS], pair};

  // Dropping the two low bits of the signed sum is an arithmetic shift, i.e. floor(sum/4).
  always_comb begin
    result = quad_sum[BITS+1:2];
    if (mode == POOL_MAX) begin
      result = (buf_rd >= pair) ? buf_rd[BITS-1:0] : pair[BITS-1:0];
    end
  end

  // NOTE: held sample and line buffer are always written before being read, so they carry no reset.
  always_ff @(posedge clk_in) begin
    if (accept && !col_odd) held_q <= sample;
    if (accept && col_odd && !row_odd) line_buf[idx] <= pair;
  end

endmodule

// File: rtl/layer_pool_stream.sv
// Streaming 2x2 max/average pooling over a raster frame of CH-channel pixels.
// Shared FSM and col/row counters drive one pool_ch_unit per channel.
module layer_pool_stream
  import pool_pkg::*;
#(
  parameter int BITS  = 16,
  parameter int CH    = 16,
  parameter int IMG_W = 24,
  parameter int IMG_H = 24
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 mode,
  input  logic                 in_valid,
  input  logic [CH*BITS-1:0]   in_data,
  output logic                 out_valid,
  output logic [CH*BITS-1:0]   out_data,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int COL_W = ctr_width(IMG_W);
  localparam int ROW_W = ctr_width(IMG_H);
  localparam int IDX_W = COL_W - 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  pool_state_e          state_q, state_d;
  pool_mode_e           mode_q;
  logic [COL_W-1:0]     col_q;
  logic [ROW_W-1:0]     row_q;
  logic                 accept, last_beat, out_hit;
  logic [CH*BITS-1:0]   pooled;

  // A start beat restarts the frame, so its own in_valid is never consumed.
  assign accept    = (state_q == ST_RUN) && in_valid && !start;
  assign last_beat = accept && (col_q == COL_LAST) && (row_q == ROW_LAST);
  assign out_hit   = accept && col_q[0] && row_q[0];

  always_comb begin
    state_d = state_q;
    if (start) state_d = ST_RUN;
    else if (last_beat) state_d = ST_IDLE;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    // NOTE: all clocked state uses non-blocking assignment so every register samples pre-edge values.
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      col_q      <= '0;
      row_q      <= '0;
      mode_q     <= POOL_MAX;
      out_valid  <= 1'b0;
      out_data   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (start) begin
        col_q  <= '0;
        row_q  <= '0;
        mode_q <= pool_mode_e'(mode);
      end else if (accept) begin
        if (col_q == COL_LAST) begin
          col_q <= '0;
          row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
      out_valid  <= out_hit;
      frame_done <= last_beat;
      if (out_hit) out_data <= pooled;
      // busy stays up through the frame_done cycle and drops on the edge after it.
      if (start)           busy <= 1'b1;
      else if (frame_done) busy <= 1'b0;
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_ch
    pool_ch_unit #(
      .BITS  (BITS),
      .IMG_W (IMG_W),
      .IDX_W (IDX_W)
    ) u_unit (
      .clk_in  (clk_in),
      .accept  (accept),
      .col_odd (col_q[0]),
      .row_odd (row_q[0]),
      .idx     (col_q[COL_W-1:1]),
      .mode    (mode_q),
      .sample  (in_data[k*BITS +: BITS]),
      .result  (pooled[k*BITS +: BITS])
    );
  end

endmodule

// File: tb/tb_layer_pool_stream.sv
// Scoreboard bench for layer_pool_stream: randomized frames against a 2x2 pooling
// reference computed from the whole-pixel window with plain integer arithmetic.
module tb_layer_pool_stream;

  localparam int BITS = 16;
  localparam int CH   = 2;
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int DW   = CH * BITS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid, busy, frame_done;
  logic [DW-1:0] out_data;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   cur_mode = 0;
  int   pix [CH][H][W];

  layer_pool_stream #(
    .BITS  (BITS),
    .CH    (CH),
    .IMG_W (W),
    .IMG_H (H)
  ) dut (
    .clk_in     (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mode       (mode),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, n_bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // pat 0: ramp (even ch = i, odd ch = -i); pat 1: extremes; otherwise random.
  function automatic logic [DW-1:0] make_pix(input int pat, input int i);
    logic [DW-1:0] p;
    int v;
    p = '0;
    for (int k = 0; k < CH; k++) begin
      if (pat == 0)      v = (k % 2 == 0) ? i : -i;
      else if (pat == 1) v = (k % 2 == 0) ? 32767 : -32768;
      else               v = int'($urandom_range(65535, 0)) - 32768;
      p[k*BITS +: BITS] = v[BITS-1:0];
    end
    return p;
  endfunction

  task automatic send_beat(input logic [DW-1:0] d, input int r, input int c, input int max_gap);
    int g;
    exp_t e;
    logic [DW-1:0] exp_d;
    g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (g) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = DW'($urandom);
      mode     = 1'($urandom_range(1, 0));
    end
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = d;
    mode     = 1'($urandom_range(1, 0));
    for (int k = 0; k < CH; k++) pix[k][r][c] = int'($signed(d[k*BITS +: BITS]));
    if ((r % 2 == 1) && (c % 2 == 1)) begin
      exp_d = '0;
      for (int k = 0; k < CH; k++) begin
        int a, b, x, y, v;
        a = pix[k][r-1][c-1];
        b = pix[k][r-1][c];
        x = pix[k][r][c-1];
        y = pix[k][r][c];
        if (cur_mode == 0) begin
          v = a;
          if (b > v) v = b;
          if (x > v) v = x;
          if (y > v) v = y;
        end else begin
          v = (a + b + x + y) >>> 2;
        end
        exp_d[k*BITS +: BITS] = v[BITS-1:0];
      end
      e.data = exp_d;
      e.last = (r == H - 1) && (c == W - 1);
      e.cyc  = cyc + 1;
      exp_q.push_back(e);
    end
  endtask

  task automatic do_start(input int m);
    @(posedge clk); #1;
    start    = 1'b1;
    mode     = m[0];
    in_valid = 1'b1;
    in_data  = DW'($urandom);
    cur_mode = m;
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic run_frame(input int m, input int pat, input int gap, input int nbeats);
    do_start(m);
    for (int i = 0; i < nbeats; i++) send_beat(make_pix(pat, i), i / W, i % W, gap);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
    @(negedge clk);
    check("busy_after_frame", busy, 0);
    check("out_valid_idle", out_valid, 0);
  endtask

  // Monitor: every out_valid pops one expected pooled pixel.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", out_valid, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_data", out_data, mon_e.data);
          check("frame_done", frame_done, mon_e.last);
          check("out_cycle", cyc, mon_e.cyc);
          if (mon_e.last) check("busy_at_done", busy, 1);
        end
      end else if (frame_done) begin
        check("stray_frame_done", frame_done, 0);
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    // Beats in IDLE must be ignored.
    repeat (6) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = DW'($urandom);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("idle_busy", busy, 0);

    run_frame(0, 0, 0, W*H);  wait_drain();   // max, ramp
    run_frame(1, 0, 0, W*H);  wait_drain();   // avg, ramp
    run_frame(1, 1, 0, W*H);  wait_drain();   // avg, extremes
    run_frame(0, 0, 3, W*H);  wait_drain();   // max, ramp with stalls
    for (int f = 0; f < 6; f++) begin
      run_frame(f % 2, 2, 3, W*H);
      wait_drain();
    end

    // Restart: six beats (one pooled output), then a fresh full frame.
    run_frame(0, 0, 0, 6);
    run_frame(1, 2, 2, W*H);
    wait_drain();

    // Reset mid-frame while out_valid is high.
    do_start(0);
    for (int i = 0; i < 6; i++) send_beat(make_pix(2, i), i / W, i % W, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_frame_done", frame_done, 0);
    check("midrst_out_data", out_data, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = DW'($urandom);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("postrst_busy", busy, 0);
    run_frame(1, 2, 1, W*H);
    wait_drain();

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
